// File: rtl/button_events.sv
// Turns a debounced button level into press/release pulses, a long-hold level and auto-repeat pulses.
// Auto-repeat is built only when BUTTON_EVENTS_REPEAT_EN is defined; otherwise repeat_pulse stays 0.
module button_events #(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100,
    localparam int CNT_BITS     = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic press,
    output logic release_pulse,
    output logic hold,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD_CYCLES - 1);
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
`endif

    state_t state, state_next;
    logic [CNT_BITS-1:0] count, count_next;
    logic press_next, release_next, hold_next, repeat_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            press         <= press_next;
            release_pulse <= release_next;
            hold          <= hold_next;
            repeat_pulse  <= repeat_next;
        end
    end

    // A low input always wins over a counter terminal, so release never coincides with hold/repeat.
    always_comb begin
        state_next   = state;
        count_next   = count;
        press_next   = 1'b0;
        release_next = 1'b0;
        hold_next    = hold;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                hold_next = 1'b0;
                if (in) begin
                    state_next = PRESSED;
                    count_next = '0;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hold_next    = 1'b0;
                end else if (count == HOLD_LAST) begin
                    state_next = HELD;
                    hold_next  = 1'b1;
                    count_next = '0;
`ifdef BUTTON_EVENTS_REPEAT_EN
                    repeat_next = 1'b1;
`endif
                end else begin
                    count_next = count + 1'b1;
                end
            end
            HELD: begin
                if (!in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hold_next    = 1'b0;
                end else begin
`ifdef BUTTON_EVENTS_REPEAT_EN
                    if (count == REPEAT_LAST) begin
                        repeat_next = 1'b1;
                        count_next  = '0;
                    end else begin
                        count_next = count + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                hold_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_events.sv
// Directed, table-driven bench for button_events with HOLD_CYCLES=8, REPEAT_CYCLES=3.
// Expected repeat pulses follow BUTTON_EVENTS_REPEAT_EN, matching whichever build is compiled.
module tb_button_events;

    localparam int HOLD = 8;
    localparam int RPT  = 3;
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic REP = 1'b1;
`else
    localparam logic REP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic in;
    logic press, release_pulse, hold, repeat_pulse;

    int errors = 0;
    int checks = 0;

    // exp packs {press, release, hold, repeat} as seen just after the edge that sampled in
    typedef struct {
        logic       in;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    button_events #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .press        (press),
        .release_pulse(release_pulse),
        .hold         (hold),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clock = ~clock;

    task automatic add(input string name, input logic i, input logic p, input logic r,
                       input logic h, input logic rp);
        vec_t v;
        v.in   = i;
        v.exp  = {p, r, h, rp};
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {press, release_pulse, hold, repeat_pulse};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: press/release/hold/repeat got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic i);
        @(negedge clock);
        in = i;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Idle after reset
        for (int k = 0; k < 20; k++) add("idle", 1'b0, 0, 0, 0, 0);
        // Short press: four sampled highs, then release
        add("short press", 1'b1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) add("short mid", 1'b1, 0, 0, 0, 0);
        add("short release", 1'b0, 0, 1, 0, 0);
        add("short after", 1'b0, 0, 0, 0, 0);
        // Long press: twenty sampled highs; release lands on a repeat terminal and still wins
        add("long press", 1'b1, 1, 0, 0, 0);
        for (int k = 1; k < HOLD; k++) add("long wait", 1'b1, 0, 0, 0, 0);
        add("long hold", 1'b1, 0, 0, 1, REP);
        for (int k = HOLD + 1; k < 20; k++)
            add("long held", 1'b1, 0, 0, 1, (k == 11 || k == 14 || k == 17) ? REP : 1'b0);
        add("long release", 1'b0, 0, 1, 0, 0);
        add("long after", 1'b0, 0, 0, 0, 0);
        // Release exactly on the hold terminal edge
        add("edge press", 1'b1, 1, 0, 0, 0);
        for (int k = 1; k < HOLD; k++) add("edge wait", 1'b1, 0, 0, 0, 0);
        add("edge release", 1'b0, 0, 1, 0, 0);
        add("edge after", 1'b0, 0, 0, 0, 0);
        // Minimum one-edge press
        add("blip press", 1'b1, 1, 0, 0, 0);
        add("blip release", 1'b0, 0, 1, 0, 0);
        add("blip after", 1'b0, 0, 0, 0, 0);

        in    = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset state", 4'b0000);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].in);
            checkOutput($sformatf("%s #%0d", vecs[n].name, n), vecs[n].exp);
        end

        // Async reset while held: no release, then a fresh press once reset drops with in high
        applyStimulus(1'b1);
        checkOutput("held press", 4'b1000);
        for (int k = 1; k < HOLD; k++) applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("held hold", {3'b001, REP});
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async clear", 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            checkOutput("in reset", 4'b0000);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("press after reset", 4'b1000);
        applyStimulus(1'b0);
        checkOutput("release after reset", 4'b0100);
        applyStimulus(1'b0);
        checkOutput("quiet after reset", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
